// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, types and constants for the instruction-fetch stage
package fetch_pkg;
  localparam int XLEN = 32;
  typedef logic [XLEN-1:0] pc_t;
  typedef logic [XLEN-1:0] instr_t;
  typedef struct packed {
    logic   valid;
    pc_t    pc;
    instr_t instruction;
  } ifid_t;
  localparam instr_t NOP_INSTR = '0;
endpackage

// File: rtl/fetch_pc_gen.sv
// pc_gen: program-counter register with reset/redirect/increment/hold next-PC mux
module pc_gen import fetch_pkg::*; #(
  parameter int N = XLEN,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  input  logic         inc,
  output logic [N-1:0] pc_q
);
  logic [N-1:0] pc_d;
  always_comb pc_d = redirect_valid ? redirect_pc : inc ? pc_q + 1'b1 : pc_q;
  always_ff @(posedge clk)
    if (!rst_n) pc_q <= RESET_PC;
    else pc_q <= pc_d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner driving imem plus IF/ID valid/ready register; optional FETCH_BOUND_CHECK_EN flags fetches at pc>=INS
module fetch_stage import fetch_pkg::*; #(
  parameter int N = XLEN,
  parameter int INS = 10,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fetch_en,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc,
  output logic [N-1:0] imem_pc,
  input  logic [N-1:0] imem_instruction,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_pc,
  output logic [N-1:0] out_instruction,
  output logic         fetch_fault
);
  ifid_t ifid_q, ifid_d;
  logic [N-1:0] pc_q;
  logic load, oob;
  pc_gen #(.N(N), .RESET_PC(RESET_PC)) u_pc_gen (
    .clk(clk),
    .rst_n(rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .inc(load && !oob),
    .pc_q(pc_q)
  );
  always_comb begin
    load = fetch_en && (!ifid_q.valid || out_ready);
    ifid_d = ifid_q;
    if (redirect_valid) ifid_d.valid = 1'b0;
    else if (load) ifid_d = oob ? '{valid: 1'b0, pc: ifid_q.pc, instruction: ifid_q.instruction}
                                : '{valid: 1'b1, pc: pc_q, instruction: imem_instruction};
    else if (ifid_q.valid && out_ready) ifid_d.valid = 1'b0;
  end
  always_ff @(posedge clk)
    if (!rst_n) ifid_q <= '{valid: 1'b0, pc: '0, instruction: NOP_INSTR};
    else ifid_q <= ifid_d;
`ifdef FETCH_BOUND_CHECK_EN
  logic fault_q, fault_d;
  always_comb begin
    oob = pc_q >= N'(INS);
    fault_d = redirect_valid ? fault_q && (redirect_pc >= N'(INS)) : fault_q || (load && oob);
  end
  always_ff @(posedge clk)
    if (!rst_n) fault_q <= 1'b0;
    else fault_q <= fault_d;
  assign fetch_fault = fault_q;
`else
  assign oob = 1'b0;
  assign fetch_fault = 1'b0;
`endif
  assign imem_pc = pc_q;
  assign out_valid = ifid_q.valid;
  assign out_pc = ifid_q.pc;
  assign out_instruction = ifid_q.instruction;
endmodule
